dcache_core: RTL and testbench

DCACHE_CORE -- requirements
Module: dcache_core

---
 rtl/dcache_core.sv | 230 +++++++++++++++++++++++
 tb/tb_dcache_core.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_core.sv
// dcache_core: direct-mapped, write-through / no-write-allocate L1 data cache (16 sets x 4 words).
// Hit/miss statistics counters are built only when DCACHE_STATS_EN is defined.

module dcache_byte_lane (
  input  logic [7:0] old_i,
  input  logic [7:0] new_i,
  input  logic       en_i,
  output logic [7:0] byte_o
);
  assign byte_o = en_i ? new_i : old_i;
endmodule

module dcache_core (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  is_dmem_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  output logic [31:0] rdata_o,
  output logic        DCache_ready_o,
  output logic        mem_rd_req_o,
  output logic [31:0] mem_rd_addr_o,
  input  logic        mem_rd_valid_i,
  input  logic [31:0] mem_rd_data_i,
  input  logic        mem_rd_last_i,
  output logic        mem_wr_req_o,
  output logic [31:0] mem_wr_addr_o,
  output logic [31:0] mem_wr_data_o,
  output logic [3:0]  mem_wr_strb_o,
  input  logic        mem_wr_ready_i,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] miss_cnt_o
);
  localparam int NUM_SETS  = 16;
  localparam int WORDS     = 4;
  localparam int NUM_LANES = 4;
  localparam int TAG_W     = 24;

  typedef enum logic [1:0] {IDLE = 2'd0, REFILL = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_e;

  typedef struct packed {
    logic        is_load;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_e state_q, state_d;
  req_t   req_q, req_d;
  logic [1:0] beat_q, beat_d;
  logic       full_q, full_d;
  logic       cancel_q, cancel_d;

  logic [NUM_SETS-1:0]                   valid_q;
  logic [NUM_SETS-1:0][TAG_W-1:0]        tag_q;
  logic [NUM_SETS-1:0][WORDS-1:0][31:0]  data_q;

  logic       cpu_ld, cpu_st, cpu_none;
  logic [3:0] idx_cur, idx_r;
  logic [1:0] off_cur, off_r;
  logic [TAG_W-1:0] tag_cur, tag_r;
  logic       hit_cur, hit_r;

  assign cpu_ld   = (is_dmem_i == 2'b01);
  assign cpu_st   = (is_dmem_i == 2'b10);
  assign cpu_none = !(cpu_ld || cpu_st);

  assign idx_cur = addr_i[7:4];
  assign off_cur = addr_i[3:2];
  assign tag_cur = addr_i[31:8];
  assign idx_r   = req_q.addr[7:4];
  assign off_r   = req_q.addr[3:2];
  assign tag_r   = req_q.addr[31:8];

  assign hit_cur = valid_q[idx_cur] && (tag_q[idx_cur] == tag_cur);
  assign hit_r   = valid_q[idx_r]   && (tag_q[idx_r]   == tag_r);

  // Store merge: one byte lane per write strobe bit
  logic [NUM_LANES-1:0][7:0] old_b, new_b, mrg_b;
  assign old_b = data_q[idx_r][off_r];
  assign new_b = req_q.wdata;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    dcache_byte_lane u_lane (
      .old_i  (old_b[l]),
      .new_i  (new_b[l]),
      .en_i   (req_q.wstrb[l]),
      .byte_o (mrg_b[l])
    );
  end

  logic        ready, rd_req, wr_req;
  logic [31:0] rd_word;
  logic        refill_we, line_done, store_we, inv_we;
  logic        hit_evt, miss_evt;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    beat_d    = beat_q;
    full_d    = full_q;
    cancel_d  = cancel_q;
    ready     = 1'b0;
    rd_word   = '0;
    rd_req    = 1'b0;
    wr_req    = 1'b0;
    refill_we = 1'b0;
    line_done = 1'b0;
    store_we  = 1'b0;
    inv_we    = 1'b0;
    hit_evt   = 1'b0;
    miss_evt  = 1'b0;
    case (state_q)
      IDLE: begin
        cancel_d = 1'b0;
        beat_d   = 2'd0;
        full_d   = 1'b0;
        if (cpu_ld || cpu_st) begin
          req_d.is_load = cpu_ld;
          req_d.addr    = {addr_i[31:2], 2'b00};
          req_d.wdata   = wdata_i;
          req_d.wstrb   = wstrb_i;
        end
        if (cpu_ld) begin
          if (hit_cur) begin
            ready   = 1'b1;
            rd_word = data_q[idx_cur][off_cur];
            hit_evt = 1'b1;
          end else begin
            // Line is invalid while it is being overwritten
            inv_we   = 1'b1;
            miss_evt = 1'b1;
            state_d  = REFILL;
          end
        end else if (cpu_st) begin
          state_d = WRITE;
        end
      end
      REFILL: begin
        rd_req = 1'b1;
        if (cpu_none) cancel_d = 1'b1;
        if (mem_rd_valid_i) begin
          refill_we = !full_q;
          if (beat_q == 2'd3) full_d = 1'b1;
          else                beat_d = beat_q + 2'd1;
          if (mem_rd_last_i) begin
            line_done = 1'b1;
            state_d   = (cancel_q || cpu_none) ? IDLE : RESP;
          end
        end
      end
      WRITE: begin
        wr_req = 1'b1;
        if (cpu_none) cancel_d = 1'b1;
        if (mem_wr_ready_i) begin
          store_we = hit_r;
          state_d  = (cancel_q || cpu_none) ? IDLE : RESP;
        end
      end
      RESP: begin
        ready   = 1'b1;
        rd_word = req_q.is_load ? data_q[idx_r][off_r] : 32'd0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      req_q    <= '0;
      beat_q   <= 2'd0;
      full_q   <= 1'b0;
      cancel_q <= 1'b0;
      valid_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      beat_q   <= beat_d;
      full_q   <= full_d;
      cancel_q <= cancel_d;
      if (inv_we)    valid_q[idx_cur] <= 1'b0;
      if (line_done) valid_q[idx_r]   <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (refill_we) data_q[idx_r][beat_q] <= mem_rd_data_i;
      if (store_we)  data_q[idx_r][off_r]  <= mrg_b;
      if (line_done) tag_q[idx_r]          <= tag_r;
    end
  end

  assign DCache_ready_o = ready && !cpu_none && !rst_i;
  assign rdata_o        = DCache_ready_o ? rd_word : 32'd0;
  assign mem_rd_req_o   = rd_req && !rst_i;
  assign mem_rd_addr_o  = {req_q.addr[31:4], 4'b0000};
  assign mem_wr_req_o   = wr_req && !rst_i;
  assign mem_wr_addr_o  = req_q.addr;
  assign mem_wr_data_o  = req_q.wdata;
  assign mem_wr_strb_o  = req_q.wstrb;

  logic unused_bits;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      if (hit_evt)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_evt) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o   = rst_i ? 32'd0 : hit_cnt_q;
  assign miss_cnt_o  = rst_i ? 32'd0 : miss_cnt_q;
  assign unused_bits = ^addr_i[1:0];
`else
  assign hit_cnt_o   = 32'd0;
  assign miss_cnt_o  = 32'd0;
  assign unused_bits = ^{addr_i[1:0], hit_evt, miss_evt};
`endif

endmodule

// File: tb/tb_dcache_core.sv
// Self-checking bench for dcache_core: directed scenarios plus randomized loads/stores
// against a cache/memory reference model.

module tb_dcache_core;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  is_dmem;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic        mem_rd_req, mem_rd_valid, mem_rd_last;
  logic [31:0] mem_rd_addr, mem_rd_data;
  logic        mem_wr_req, mem_wr_ready;
  logic [31:0] mem_wr_addr, mem_wr_data;
  logic [3:0]  mem_wr_strb;
  logic [31:0] hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  dcache_core dut (
    .clk_i(clk), .rst_i(rst), .is_dmem_i(is_dmem), .addr_i(addr), .wdata_i(wdata),
    .wstrb_i(wstrb), .rdata_o(rdata), .DCache_ready_o(ready),
    .mem_rd_req_o(mem_rd_req), .mem_rd_addr_o(mem_rd_addr), .mem_rd_valid_i(mem_rd_valid),
    .mem_rd_data_i(mem_rd_data), .mem_rd_last_i(mem_rd_last),
    .mem_wr_req_o(mem_wr_req), .mem_wr_addr_o(mem_wr_addr), .mem_wr_data_o(mem_wr_data),
    .mem_wr_strb_o(mem_wr_strb), .mem_wr_ready_i(mem_wr_ready),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  int checks = 0;
  int passed = 0;

  // Main memory and cache reference model
  logic [31:0] mem [logic [31:0]];
  bit          mvalid [16];
  logic [23:0] mtag   [16];
  logic [31:0] mline  [16][4];
  int          exp_hits, exp_misses;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w = {a[31:2], 2'b00};
    if (mem.exists(w)) return mem[w];
    return w ^ 32'h5EED_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, nw, input logic [3:0] st);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return mvalid[a[7:4]] && (mtag[a[7:4]] == a[31:8]);
  endfunction

  task automatic model_load(input logic [31:0] a, output logic [31:0] d, output bit hit);
    hit = model_hit(a);
    if (hit) exp_hits++;
    else begin
      exp_misses++;
      for (int w = 0; w < 4; w++) mline[a[7:4]][w] = mem_rd({a[31:4], 4'b0} + 32'(4*w));
      mvalid[a[7:4]] = 1'b1;
      mtag[a[7:4]]   = a[31:8];
    end
    d = mline[a[7:4]][a[3:2]];
  endtask

  task automatic model_store(input logic [31:0] a, wd, input logic [3:0] ws);
    mem[{a[31:2], 2'b00}] = merge(mem_rd(a), wd, ws);
    if (model_hit(a)) mline[a[7:4]][a[3:2]] = merge(mline[a[7:4]][a[3:2]], wd, ws);
  endtask

  task automatic model_reset();
    for (int s = 0; s < 16; s++) mvalid[s] = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
  endtask

  // Memory side: refill beats after rd_gap idle cycles each, write accept after wr_delay cycles
  int rd_gap = 0, wr_delay = 0;
  int rd_beat = 0, gap_ctr = 0, wr_ctr = 0;

  initial begin
    mem_rd_valid = 1'b0; mem_rd_last = 1'b0; mem_rd_data = '0;
    forever begin
      @(posedge clk); #1;
      mem_rd_valid = 1'b0;
      mem_rd_last  = 1'b0;
      if (mem_rd_req) begin
        if (gap_ctr < rd_gap) gap_ctr++;
        else begin
          gap_ctr      = 0;
          mem_rd_valid = 1'b1;
          mem_rd_data  = mem_rd(mem_rd_addr + 32'(4*rd_beat));
          mem_rd_last  = (rd_beat == 3);
          rd_beat      = (rd_beat == 3) ? 0 : rd_beat + 1;
        end
      end else begin
        rd_beat = 0;
        gap_ctr = 0;
      end
    end
  end

  initial begin
    mem_wr_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      mem_wr_ready = 1'b0;
      if (mem_wr_req) begin
        if (wr_ctr >= wr_delay) begin mem_wr_ready = 1'b1; wr_ctr = 0; end
        else wr_ctr++;
      end else wr_ctr = 0;
    end
  end

  // Bus monitor: event counters and last-seen payloads
  int ready_cnt = 0, rdreq_cnt = 0, wrreq_cnt = 0, both_cnt = 0, wr_unstable = 0;
  logic [31:0] rd_addr_seen = '0;
  logic [67:0] wr_pay_seen = '0;
  bit          wr_prev = 0;

  always @(negedge clk) begin
    if (ready === 1'b1) ready_cnt++;
    if (mem_rd_req === 1'b1) begin rdreq_cnt++; rd_addr_seen = mem_rd_addr; end
    if (mem_wr_req === 1'b1) begin
      if (wr_prev && ({mem_wr_addr, mem_wr_data, mem_wr_strb} !== wr_pay_seen)) wr_unstable++;
      wr_pay_seen = {mem_wr_addr, mem_wr_data, mem_wr_strb};
      wr_prev = 1;
      wrreq_cnt++;
    end else wr_prev = 0;
    if (mem_rd_req === 1'b1 && mem_wr_req === 1'b1) both_cnt++;
  end

  // Issue one CPU request and hold it until DCache_ready (bounded); lat = stall cycles
  task automatic cpu_op(input logic [1:0] op, input logic [31:0] a, wd, input logic [3:0] ws,
                        output logic [31:0] rd, output int lat, output bit ok);
    is_dmem = op; addr = a; wdata = wd; wstrb = ws;
    ok = 0; lat = 0; rd = '0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ready === 1'b1) begin rd = rdata; ok = 1; break; end
      lat++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    is_dmem = 2'b00;
  endtask

  task automatic test_reset();
    rst = 1'b1; is_dmem = 2'b01; addr = 32'h104; wdata = '0; wstrb = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", ready); else passed++;
    checks++; if (rdata !== 32'd0) $display("FAIL rst_rdata got %h exp 0", rdata); else passed++;
    checks++; if (mem_rd_req !== 1'b0) $display("FAIL rst_rd_req got %b exp 0", mem_rd_req); else passed++;
    checks++; if (mem_wr_req !== 1'b0) $display("FAIL rst_wr_req got %b exp 0", mem_wr_req); else passed++;
    checks++; if (hit_cnt !== 32'd0) $display("FAIL rst_hit_cnt got %0d exp 0", hit_cnt); else passed++;
    checks++; if (miss_cnt !== 32'd0) $display("FAIL rst_miss_cnt got %0d exp 0", miss_cnt); else passed++;
    @(posedge clk); #1;
    rst = 1'b0; is_dmem = 2'b00;
    model_reset();
  endtask

  task automatic test_cold_miss();
    logic [31:0] rd, exp_d; int lat; bit ok, hit; int r0;
    for (int w = 0; w < 4; w++) mem[32'h100 + 32'(4*w)] = 32'hA0 + 32'(w);
    rd_gap = 1;
    r0 = ready_cnt;
    model_load(32'h104, exp_d, hit);
    cpu_op(2'b01, 32'h104, '0, '0, rd, lat, ok);
    checks++; if (!ok) $display("FAIL cold_done no ready within bound"); else passed++;
    checks++; if ((lat == 0) !== hit) $display("FAIL cold_hitflag lat %0d exp_hit %0d", lat, hit); else passed++;
    checks++; if (rd !== exp_d) $display("FAIL cold_rdata got %h exp %h", rd, exp_d); else passed++;
    checks++; if (rd_addr_seen !== 32'h100) $display("FAIL cold_rd_addr got %h exp 00000100", rd_addr_seen); else passed++;
    repeat (2) @(posedge clk);
    checks++; if (ready_cnt - r0 !== 1) $display("FAIL cold_ready_pulses got %0d exp 1", ready_cnt - r0); else passed++;
    #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_d; bit hit; int rr0;
    rr0 = rdreq_cnt;
    is_dmem = 2'b01; addr = 32'h104;
    for (int i = 0; i < 3; i++) begin
      model_load(32'h104, exp_d, hit);
      @(negedge clk);
      checks++; if (ready !== hit) $display("FAIL b2b_ready[%0d] got %b exp %b", i, ready, hit); else passed++;
      checks++; if (rdata !== exp_d) $display("FAIL b2b_rdata[%0d] got %h exp %h", i, rdata, exp_d); else passed++;
      @(posedge clk); #1;
    end
    is_dmem = 2'b00;
    @(negedge clk);
    checks++; if (rdreq_cnt !== rr0) $display("FAIL b2b_no_refill got %0d rd_req cycles exp 0", rdreq_cnt - rr0); else passed++;
`ifdef DCACHE_STATS_EN
    checks++; if (hit_cnt !== 32'(exp_hits)) $display("FAIL b2b_hit_cnt got %0d exp %0d", hit_cnt, exp_hits); else passed++;
    checks++; if (miss_cnt !== 32'(exp_misses)) $display("FAIL b2b_miss_cnt got %0d exp %0d", miss_cnt, exp_misses); else passed++;
`else
    checks++; if (hit_cnt !== 32'd0) $display("FAIL b2b_hit_cnt got %0d exp 0", hit_cnt); else passed++;
    checks++; if (miss_cnt !== 32'd0) $display("FAIL b2b_miss_cnt got %0d exp 0", miss_cnt); else passed++;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_store_hit();
    logic [31:0] rd, exp_d; int lat; bit ok, hit; int w0, u0;
    wr_delay = 4;
    w0 = wrreq_cnt; u0 = wr_unstable;
    model_store(32'h104, 32'hFFFF_FFFF, 4'b0011);
    cpu_op(2'b10, 32'h104, 32'hFFFF_FFFF, 4'b0011, rd, lat, ok);
    checks++; if (!ok) $display("FAIL st_done no ready within bound"); else passed++;
    checks++; if (wrreq_cnt - w0 !== wr_delay + 1) $display("FAIL st_wr_req_cycles got %0d exp %0d", wrreq_cnt - w0, wr_delay + 1); else passed++;
    checks++; if (wr_pay_seen !== {32'h104, 32'hFFFF_FFFF, 4'b0011}) $display("FAIL st_payload got %h exp %h", wr_pay_seen, {32'h104, 32'hFFFF_FFFF, 4'b0011}); else passed++;
    checks++; if (wr_unstable !== u0) $display("FAIL st_stable got %0d changes exp 0", wr_unstable - u0); else passed++;
    model_load(32'h104, exp_d, hit);
    cpu_op(2'b01, 32'h104, '0, '0, rd, lat, ok);
    checks++; if ((lat == 0) !== hit || !ok) $display("FAIL st_reload_hit lat %0d exp_hit %0d", lat, hit); else passed++;
    checks++; if (rd !== exp_d) $display("FAIL st_reload_rdata got %h exp %h", rd, exp_d); else passed++;
  endtask

  task automatic test_conflict();
    logic [31:0] rd, exp_d; int lat; bit ok, hit;
    rd_gap = 0;
    model_load(32'h1104, exp_d, hit);
    cpu_op(2'b01, 32'h1104, '0, '0, rd, lat, ok);
    checks++; if ((lat == 0) !== hit || !ok) $display("FAIL cf_first_miss lat %0d exp_hit %0d", lat, hit); else passed++;
    checks++; if (rd !== exp_d) $display("FAIL cf_first_rdata got %h exp %h", rd, exp_d); else passed++;
    checks++; if (rd_addr_seen !== 32'h1100) $display("FAIL cf_rd_addr got %h exp 00001100", rd_addr_seen); else passed++;
    model_load(32'h104, exp_d, hit);
    cpu_op(2'b01, 32'h104, '0, '0, rd, lat, ok);
    checks++; if ((lat == 0) !== hit || !ok) $display("FAIL cf_second_miss lat %0d exp_hit %0d", lat, hit); else passed++;
    checks++; if (rd !== exp_d) $display("FAIL cf_second_rdata got %h exp %h", rd, exp_d); else passed++;
  endtask

  task automatic test_cancel_reset();
    logic [31:0] rd, exp_d; int lat; bit ok, hit, done; int r0, rr0;
    // Drop the request mid-refill: line still fills, no ready pulse
    rd_gap = 1;
    r0 = ready_cnt;
    model_load(32'h2238, exp_d, hit);
    is_dmem = 2'b01; addr = 32'h2238;
    repeat (2) @(posedge clk); #1;
    is_dmem = 2'b00;
    done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_rd_req === 1'b0) begin done = 1; break; end
    end
    checks++; if (!done) $display("FAIL cancel_refill_end mem_rd_req still high after bound"); else passed++;
    repeat (2) @(posedge clk); #1;
    checks++; if (ready_cnt !== r0) $display("FAIL cancel_no_ready got %0d pulses exp 0", ready_cnt - r0); else passed++;
    checks++; if (rd_addr_seen !== 32'h2230) $display("FAIL cancel_rd_addr got %h exp 00002230", rd_addr_seen); else passed++;
    model_load(32'h2238, exp_d, hit);
    cpu_op(2'b01, 32'h2238, '0, '0, rd, lat, ok);
    checks++; if ((lat == 0) !== hit || !ok) $display("FAIL cancel_line_hit lat %0d exp_hit %0d", lat, hit); else passed++;
    checks++; if (rd !== exp_d) $display("FAIL cancel_line_rdata got %h exp %h", rd, exp_d); else passed++;
    // Reset mid-refill: request drops after the reset edge, line stays invalid
    rd_gap = 2;
    is_dmem = 2'b01; addr = 32'h3340;
    repeat (5) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; is_dmem = 2'b00;
    model_reset();
    @(negedge clk);
    checks++; if (mem_rd_req !== 1'b0) $display("FAIL rstmid_rd_req got %b exp 0", mem_rd_req); else passed++;
    @(posedge clk); #1;
    rr0 = rdreq_cnt;
    model_load(32'h3340, exp_d, hit);
    cpu_op(2'b01, 32'h3340, '0, '0, rd, lat, ok);
    checks++; if ((lat == 0) !== hit || !ok) $display("FAIL rstmid_miss lat %0d exp_hit %0d", lat, hit); else passed++;
    checks++; if ((rdreq_cnt != rr0) !== !hit) $display("FAIL rstmid_refill rd_req cycles %0d exp_hit %0d", rdreq_cnt - rr0, hit); else passed++;
    checks++; if (rd !== exp_d) $display("FAIL rstmid_rdata got %h exp %h", rd, exp_d); else passed++;
  endtask

  task automatic test_random();
    logic [23:0] tags [3];
    logic [31:0] a, wd, rd, exp_d; logic [3:0] ws; int lat; bit ok, hit; int rr0, w0;
    tags[0] = 24'h000000; tags[1] = 24'h000011; tags[2] = 24'h000ABC;
    for (int n = 0; n < 120; n++) begin
      a = {tags[$urandom_range(0, 2)], 4'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      rd_gap = $urandom_range(0, 2);
      wr_delay = $urandom_range(0, 3);
      if ($urandom_range(0, 9) < 6) begin
        rr0 = rdreq_cnt;
        model_load(a, exp_d, hit);
        cpu_op(2'b01, a, '0, '0, rd, lat, ok);
        checks++; if (!ok || (lat == 0) !== hit) $display("FAIL rnd_ld_hit[%0d] a %h lat %0d exp_hit %0d", n, a, lat, hit); else passed++;
        checks++; if ((rdreq_cnt != rr0) !== !hit) $display("FAIL rnd_ld_refill[%0d] a %h rd_req cycles %0d exp_hit %0d", n, a, rdreq_cnt - rr0, hit); else passed++;
        checks++; if (rd !== exp_d) $display("FAIL rnd_ld_rdata[%0d] a %h got %h exp %h", n, a, rd, exp_d); else passed++;
      end else begin
        wd = $urandom; ws = 4'($urandom_range(1, 15));
        w0 = wrreq_cnt;
        model_store(a, wd, ws);
        cpu_op(2'b10, a, wd, ws, rd, lat, ok);
        checks++; if (!ok || lat == 0) $display("FAIL rnd_st_done[%0d] a %h ok %0d lat %0d", n, a, ok, lat); else passed++;
        checks++; if (wrreq_cnt - w0 !== wr_delay + 1) $display("FAIL rnd_st_cycles[%0d] got %0d exp %0d", n, wrreq_cnt - w0, wr_delay + 1); else passed++;
        checks++; if (wr_pay_seen !== {a[31:2], 2'b00, wd, ws}) $display("FAIL rnd_st_payload[%0d] got %h exp %h", n, wr_pay_seen, {a[31:2], 2'b00, wd, ws}); else passed++;
      end
    end
    @(negedge clk);
    checks++; if (both_cnt !== 0) $display("FAIL rd_wr_exclusive got %0d overlap cycles exp 0", both_cnt); else passed++;
    checks++; if (wr_unstable !== 0) $display("FAIL wr_payload_stable got %0d changes exp 0", wr_unstable); else passed++;
`ifdef DCACHE_STATS_EN
    checks++; if (hit_cnt !== 32'(exp_hits)) $display("FAIL end_hit_cnt got %0d exp %0d", hit_cnt, exp_hits); else passed++;
    checks++; if (miss_cnt !== 32'(exp_misses)) $display("FAIL end_miss_cnt got %0d exp %0d", miss_cnt, exp_misses); else passed++;
`else
    checks++; if (hit_cnt !== 32'd0) $display("FAIL end_hit_cnt got %0d exp 0", hit_cnt); else passed++;
    checks++; if (miss_cnt !== 32'd0) $display("FAIL end_miss_cnt got %0d exp 0", miss_cnt); else passed++;
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_store_hit();
    test_conflict();
    test_cancel_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
